// File: rtl/dpb_burst_reader.sv
// rtl/dpb_burst_reader.sv - burst byte reader for a DPB block RAM port, packing bytes into a 32-bit word stream
// One byte read per cycle; bytes are packed little-endian into words held in a 2-entry output FIFO.
module dpb_burst_reader #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [LEN_W-1:0]  REQ_LEN,
  output logic              MEM_CE,
  output logic              MEM_OCE,
  output logic              MEM_WRE,
  output logic [13:0]       MEM_AD,
  input  logic [7:0]        MEM_DO,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [31:0]       OUT_DATA,
  output logic [3:0]        OUT_BEN,
  output logic              OUT_LAST,
  output logic              BUSY
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              busy_q;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   sat_len;
  logic [1:0]        issue_lane;

  logic              fly_valid;
  logic              fly_last;
  logic [1:0]        fly_lane;
  logic              fly_done;

  logic [31:0]       pack_data;
  logic [31:0]       cap_word;
  logic [3:0]        cap_ben;

  logic              head_v;
  logic              tail_v;
  logic [31:0]       head_data;
  logic [31:0]       tail_data;
  logic [3:0]        head_ben;
  logic [3:0]        tail_ben;
  logic              head_last;
  logic              tail_last;

  logic [1:0]        occ;
  logic              credit_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic              final_pop;

  always_comb begin
    if (32'(REQ_LEN) > DEPTH) begin
      sat_len = (ADDR_W+1)'(DEPTH);
    end else begin
      sat_len = (ADDR_W+1)'(REQ_LEN);
    end
  end

  // A byte whose capture will push a word (lane 3 or burst end) already owns a FIFO slot.
  assign occ       = {1'b0, head_v} + {1'b0, tail_v};
  assign fly_done  = fly_valid & ((fly_lane == 2'd3) | fly_last);
  assign credit_ok = (occ + {1'b0, fly_done}) < 2'd2;

  assign accept    = REQ_VALID & REQ_READY;
  assign push      = fly_done;
  assign pop       = head_v & OUT_READY;
  assign final_pop = pop & head_last;

  assign cap_word  = pack_data | (32'(MEM_DO) << {fly_lane, 3'b000});

  always_comb begin
    cap_ben = 4'hF;
    if (fly_last) begin
      case (fly_lane)
        2'd0:    cap_ben = 4'b0001;
        2'd1:    cap_ben = 4'b0011;
        2'd2:    cap_ben = 4'b0111;
        default: cap_ben = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    MEM_CE    = 1'b0;
    case (state)
      IDLE: begin
        REQ_READY = !RESET;
        if (REQ_VALID && !RESET && (REQ_LEN != '0)) begin
          state_nxt = READ;
        end
      end
      READ: begin
        MEM_CE = credit_ok & !RESET;
        if (credit_ok && (remaining == (ADDR_W+1)'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (final_pop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr       <= '0;
      remaining  <= '0;
      issue_lane <= '0;
      fly_valid  <= 1'b0;
      fly_lane   <= '0;
      fly_last   <= 1'b0;
      pack_data  <= '0;
    end else begin
      if (accept) begin
        addr       <= REQ_ADDR;
        remaining  <= sat_len;
        issue_lane <= '0;
      end else if (MEM_CE) begin
        addr       <= addr + ADDR_W'(1);
        remaining  <= remaining - (ADDR_W+1)'(1);
        issue_lane <= issue_lane + 2'd1;
      end
      fly_valid <= MEM_CE;
      fly_lane  <= issue_lane;
      fly_last  <= (remaining == (ADDR_W+1)'(1));
      if (fly_valid) begin
        pack_data <= push ? '0 : cap_word;
      end
    end
  end

  // Head entry drives the stream directly so the outputs come straight from flops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_v    <= 1'b0;
      tail_v    <= 1'b0;
      head_data <= '0;
      tail_data <= '0;
      head_ben  <= '0;
      tail_ben  <= '0;
      head_last <= 1'b0;
      tail_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!head_v) begin
            head_v    <= 1'b1;
            head_data <= cap_word;
            head_ben  <= cap_ben;
            head_last <= fly_last;
          end else begin
            tail_v    <= 1'b1;
            tail_data <= cap_word;
            tail_ben  <= cap_ben;
            tail_last <= fly_last;
          end
        end
        2'b01: begin
          if (tail_v) begin
            head_data <= tail_data;
            head_ben  <= tail_ben;
            head_last <= tail_last;
            tail_v    <= 1'b0;
            tail_data <= '0;
            tail_ben  <= '0;
            tail_last <= 1'b0;
          end else begin
            head_v    <= 1'b0;
            head_data <= '0;
            head_ben  <= '0;
            head_last <= 1'b0;
          end
        end
        2'b11: begin
          if (tail_v) begin
            head_data <= tail_data;
            head_ben  <= tail_ben;
            head_last <= tail_last;
            tail_data <= cap_word;
            tail_ben  <= cap_ben;
            tail_last <= fly_last;
          end else begin
            head_data <= cap_word;
            head_ben  <= cap_ben;
            head_last <= fly_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign OUT_VALID = head_v;
  assign OUT_DATA  = head_data;
  assign OUT_BEN   = head_ben;
  assign OUT_LAST  = head_last;
  assign BUSY      = busy_q;
  assign MEM_OCE   = MEM_CE;
  assign MEM_WRE   = 1'b0;
  assign MEM_AD    = {{(14-ADDR_W){1'b0}}, addr};

endmodule

// File: tb/tb_dpb_burst_reader.sv
// tb/tb_dpb_burst_reader.sv - self-checking bench for dpb_burst_reader with a byte RAM model and word scoreboard
// Expected words come from a byte-level model of each accepted request applied to the bench's memory image.
module tb_dpb_burst_reader;

  logic        CLK;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [10:0] REQ_ADDR;
  logic [11:0] REQ_LEN;
  logic        MEM_CE;
  logic        MEM_OCE;
  logic        MEM_WRE;
  logic [13:0] MEM_AD;
  logic [7:0]  MEM_DO;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_BEN;
  logic        OUT_LAST;
  logic        BUSY;

  dpb_burst_reader #(.ADDR_W(11), .LEN_W(12)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .MEM_CE(MEM_CE), .MEM_OCE(MEM_OCE), .MEM_WRE(MEM_WRE), .MEM_AD(MEM_AD), .MEM_DO(MEM_DO),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_BEN(OUT_BEN),
    .OUT_LAST(OUT_LAST), .BUSY(BUSY)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:2047];
  logic [36:0] expq[$];
  logic [10:0] ad_log[$];

  int cyc = 0, acc_count = 0, acc_cyc = 0, last_hs_cyc = 0, first_ov = -1;
  int ce_count = 0, ov_count = 0, issued = 0, popped = 0, max_out = 0;
  int ad_err = 0, stab_err = 0;
  logic [10:0] exp_ad = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] pd = '0;
  logic [3:0]  pb = '0;
  logic        pl = 1'b0;
  logic        rand_rdy = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    if (MEM_CE) MEM_DO <= mem[MEM_AD[10:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Byte i of the burst is mem[(addr+i) mod 2048]; every 4 bytes or the final byte close a word.
  function automatic void build_exp(input logic [10:0] a, input logic [11:0] l);
    int n;
    logic [31:0] w;
    logic [3:0]  be;
    n  = (l > 12'd2048) ? 2048 : int'(l);
    w  = '0;
    be = '0;
    for (int i = 0; i < n; i++) begin
      w[8*(i%4) +: 8] = mem[(int'(a) + i) % 2048];
      be[i%4] = 1'b1;
      if ((i % 4 == 3) || (i == n-1)) begin
        expq.push_back({(i == n-1), be, w});
        w  = '0;
        be = '0;
      end
    end
  endfunction

  always @(negedge CLK) begin
    logic [36:0] e;
    cyc++;
    if (RESET) begin
      expq.delete();
      prev_stall = 1'b0;
      issued = 0;
      popped = 0;
    end else begin
      if ((MEM_OCE !== MEM_CE) || (MEM_WRE !== 1'b0)) ad_err++;
      if (MEM_CE) begin
        if (MEM_AD !== {3'b000, exp_ad}) ad_err++;
        ad_log.push_back(MEM_AD[10:0]);
        exp_ad = exp_ad + 11'd1;
        ce_count++;
        issued++;
      end
      if (OUT_VALID) begin
        ov_count++;
        if (first_ov < 0) first_ov = cyc;
      end
      if (prev_stall && (!OUT_VALID || OUT_DATA !== pd || OUT_BEN !== pb || OUT_LAST !== pl)) stab_err++;
      if (OUT_VALID && OUT_READY) begin
        check("word_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("out_data", OUT_DATA, e[31:0]);
          check("out_ben", {28'd0, OUT_BEN}, {28'd0, e[35:32]});
          check("out_last", {31'd0, OUT_LAST}, {31'd0, e[36]});
        end
        popped += $countones(OUT_BEN);
        if (OUT_LAST) last_hs_cyc = cyc;
      end
      if (REQ_VALID && REQ_READY) begin
        acc_count++;
        acc_cyc  = cyc;
        ce_count = 0;
        ov_count = 0;
        first_ov = -1;
        exp_ad   = REQ_ADDR;
        ad_log.delete();
        issued = 0;
        popped = 0;
        build_exp(REQ_ADDR, REQ_LEN);
      end
      if (issued - popped > max_out) max_out = issued - popped;
      prev_stall = OUT_VALID && !OUT_READY;
      pd = OUT_DATA;
      pb = OUT_BEN;
      pl = OUT_LAST;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_req(input logic [10:0] a, input logic [11:0] l);
    int t;
    tick();
    REQ_ADDR  = a;
    REQ_LEN   = l;
    REQ_VALID = 1'b1;
    t = 0;
    @(negedge CLK);
    while (!REQ_READY && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    check("req_accept", REQ_READY, 1);
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (t < budget) begin
      tick();
      if (rand_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      if (!BUSY && expq.size() == 0) break;
      t++;
    end
    check("idle_wait", t < budget, 1);
  endtask

  function automatic int sat(input logic [11:0] l);
    return (l > 12'd2048) ? 2048 : int'(l);
  endfunction

  initial begin
    int k;
    int t;
    int base;
    logic [10:0] ea;
    logic [10:0] ra;
    logic [11:0] rl;

    RESET = 1'b1;
    REQ_VALID = 1'b0;
    REQ_ADDR = '0;
    REQ_LEN = '0;
    OUT_READY = 1'b1;
    MEM_DO = '0;
    for (int i = 0; i < 2048; i++) mem[i] = i[7:0];

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", REQ_READY, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_out_ben", {28'd0, OUT_BEN}, 0);
    check("rst_out_last", OUT_LAST, 0);
    check("rst_busy", BUSY, 0);
    check("rst_mem_ce", MEM_CE, 0);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("post_rst_req_ready", REQ_READY, 1);

    // basic burst
    send_req(11'h010, 12'd4);
    wait_idle(200);
    check("basic_first_valid", first_ov - acc_cyc, 6);
    check("basic_ce", ce_count, 4);

    // wrap and partial word
    send_req(11'h7FE, 12'd6);
    wait_idle(200);
    check("wrap_ad_count", ad_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < ad_log.size()) begin
        ea = 11'h7FE + 11'(i);
        check($sformatf("wrap_ad%0d", i), {21'd0, ad_log[i]}, {21'd0, ea});
      end
    end

    // backpressure
    tick();
    OUT_READY = 1'b0;
    max_out = 0;
    send_req(11'h000, 12'd16);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check("bp_ce_count", ce_count, 8);
    check("bp_out_valid", OUT_VALID, 1);
    check("bp_outstanding", max_out, 8);
    tick();
    OUT_READY = 1'b1;
    wait_idle(300);
    check("bp_ce_total", ce_count, 16);

    // zero length, then single byte
    send_req(11'h123, 12'd0);
    @(negedge CLK);
    check("zero_req_ready", REQ_READY, 1);
    check("zero_busy", BUSY, 0);
    repeat (4) @(negedge CLK);
    check("zero_ce", ce_count, 0);
    check("zero_ov", ov_count, 0);
    send_req(11'h020, 12'd1);
    wait_idle(200);
    check("one_ce", ce_count, 1);

    // reset mid-burst
    send_req(11'h000, 12'd64);
    k = 0;
    t = 0;
    while (k < 2 && t < 500) begin
      @(negedge CLK);
      if (OUT_VALID && OUT_READY) k++;
      t++;
    end
    check("mid_two_pops", k, 2);
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_req_ready", REQ_READY, 0);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("mid_out_valid", OUT_VALID, 0);
    check("mid_mem_ce", MEM_CE, 0);
    check("mid_busy", BUSY, 0);
    send_req(11'h100, 12'd4);
    wait_idle(200);
    check("mid_new_ce", ce_count, 4);

    // requests held high while busy
    tick();
    base = acc_count;
    REQ_ADDR  = 11'h040;
    REQ_LEN   = 12'd8;
    REQ_VALID = 1'b1;
    t = 0;
    while (acc_count < base + 1 && t < 100) begin
      tick();
      t++;
    end
    REQ_ADDR = 11'h080;
    REQ_LEN  = 12'd5;
    while (acc_count < base + 2 && t < 300) begin
      tick();
      t++;
    end
    REQ_VALID = 1'b0;
    check("busy_accept_gap", acc_cyc - last_hs_cyc, 1);
    wait_idle(300);
    check("busy_accepts", acc_count - base, 2);

    // length saturation
    send_req(11'h005, 12'hFFF);
    wait_idle(5000);
    check("sat_ce", ce_count, 2048);

    // randomized requests and backpressure
    rand_rdy = 1'b1;
    for (int it = 0; it < 24; it++) begin
      if (it % 12 == 0) begin
        tick();
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      end
      ra = 11'($urandom);
      rl = (it % 8 == 7) ? 12'($urandom_range(2040, 4095)) : 12'($urandom_range(0, 23));
      send_req(ra, rl);
      wait_idle(20000);
      check($sformatf("rand%0d_ce", it), ce_count, sat(rl));
    end
    rand_rdy = 1'b0;
    tick();
    OUT_READY = 1'b1;

    check("mem_port", ad_err, 0);
    check("hold_stable", stab_err, 0);
    check("max_outstanding", max_out <= 8, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
